brightness_sequencer: RTL and testbench

Drives the 3-bit brightness_level input of the 7-segment PWM brightness controller. It arbitrates between three requesters: manual up/down buttons, a night-mode dimming request, and an alert flash override. Level changes are applied as a timed one-step-at-a-time fade rather than as jumps. It sits between the traffic-light control/UI logic and the PWM stage, in the 125 MHz clock domain.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/ms_tick_gen.sv | 35 +++
 rtl/brightness_sequencer.sv | 144 ++++++++++++++
 tb/tb_brightness_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic-light display path.
package traffic_pkg;

    typedef logic [2:0] brightness_t;

    localparam brightness_t BRIGHT_MIN = 3'd0;
    localparam brightness_t BRIGHT_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FADE      = 2'd1,
        FLASH_ON  = 2'd2,
        FLASH_OFF = 2'd3
    } bseq_state_t;

    // One level step from cur toward tgt; callers guarantee cur != tgt.
    function automatic brightness_t step_toward(brightness_t cur, brightness_t tgt);
        return (tgt > cur) ? cur + 3'd1 : cur - 3'd1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler: one-cycle registered tick per ms.
module ms_tick_gen #(
    parameter int unsigned CLK_FREQ = 125_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned DIV   = CLK_FREQ / 1000;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             wrap_c;

    always_comb begin
        wrap_c = (cnt_q == CNT_W'(DIV - 1));
        cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
        tick_d = wrap_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/brightness_sequencer.sv
// Arbitrates buttons, night-mode clamp and alert flash into a faded
// 3-bit brightness level for the PWM stage.
module brightness_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 125_000_000,
    parameter int unsigned STEP_MS       = 50,
    parameter int unsigned FLASH_MS      = 250,
    parameter int unsigned NIGHT_LEVEL   = 2,
    parameter int unsigned DEFAULT_LEVEL = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        night_mode,
    input  logic        flash_req,
    output logic [2:0]  brightness_level,
    output logic        fading,
    output logic        flash_active
);

    localparam int unsigned STEP_W  = $clog2(STEP_MS + 1);
    localparam int unsigned FLASH_W = $clog2(FLASH_MS + 1);
    localparam brightness_t NIGHT_LVL = brightness_t'(NIGHT_LEVEL);
    localparam brightness_t DEF_LVL   = brightness_t'(DEFAULT_LEVEL);

    logic tick;

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_ms_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    bseq_state_t         state_q, state_d;
    brightness_t         user_q, user_d;
    brightness_t         cur_q, cur_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [FLASH_W-1:0]  flash_q, flash_d;
    brightness_t         level_q, level_d;
    logic                fading_q, fading_d;
    logic                flash_act_q, flash_act_d;
    brightness_t         target_c;

    always_comb begin
        state_d     = state_q;
        user_d      = user_q;
        cur_d       = cur_q;
        step_d      = step_q;
        flash_d     = flash_q;
        level_d     = level_q;
        fading_d    = fading_q;
        flash_act_d = flash_act_q;

        // Simultaneous up/down cancels out; saturate at the rails.
        if (btn_up && !btn_down && user_q != BRIGHT_MAX) begin
            user_d = user_q + 3'd1;
        end else if (btn_down && !btn_up && user_q != BRIGHT_MIN) begin
            user_d = user_q - 3'd1;
        end

        target_c = (night_mode && user_q > NIGHT_LVL) ? NIGHT_LVL : user_q;

        case (state_q)
            IDLE: begin
                if (flash_req) begin
                    state_d = FLASH_ON;
                    flash_d = '0;
                end else if (target_c != cur_q) begin
                    state_d = FADE;
                    step_d  = '0;
                end
            end
            FADE: begin
                if (flash_req) begin
                    state_d = FLASH_ON;
                    flash_d = '0;
                end else if (target_c == cur_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (step_q == STEP_W'(STEP_MS - 1)) begin
                        step_d = '0;
                        cur_d  = step_toward(cur_q, target_c);
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            FLASH_ON, FLASH_OFF: begin
                // cur_q is frozen here so the pre-flash level resumes on exit.
                if (!flash_req) begin
                    state_d = (target_c != cur_q) ? FADE : IDLE;
                    step_d  = '0;
                end else if (tick) begin
                    if (flash_q == FLASH_W'(FLASH_MS - 1)) begin
                        flash_d = '0;
                        state_d = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                    end else begin
                        flash_d = flash_q + FLASH_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            FLASH_ON:  level_d = BRIGHT_MAX;
            FLASH_OFF: level_d = BRIGHT_MIN;
            default:   level_d = cur_d;
        endcase
        fading_d    = (state_d == FADE);
        flash_act_d = (state_d == FLASH_ON) || (state_d == FLASH_OFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            user_q      <= DEF_LVL;
            cur_q       <= DEF_LVL;
            step_q      <= '0;
            flash_q     <= '0;
            level_q     <= DEF_LVL;
            fading_q    <= 1'b0;
            flash_act_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            user_q      <= user_d;
            cur_q       <= cur_d;
            step_q      <= step_d;
            flash_q     <= flash_d;
            level_q     <= level_d;
            fading_q    <= fading_d;
            flash_act_q <= flash_act_d;
        end
    end

    assign brightness_level = level_q;
    assign fading           = fading_q;
    assign flash_active     = flash_act_q;

endmodule

// File: tb/tb_brightness_sequencer.sv
// Directed bench for brightness_sequencer: tick every 10 cycles, step 2 ms, flash 3 ms.
module tb_brightness_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       night_mode;
    logic       flash_req;
    logic [2:0] brightness_level;
    logic       fading;
    logic       flash_active;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned el;

    brightness_sequencer #(
        .CLK_FREQ      (10_000),
        .STEP_MS       (2),
        .FLASH_MS      (3),
        .NIGHT_LEVEL   (2),
        .DEFAULT_LEVEL (5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_up           (btn_up),
        .btn_down         (btn_down),
        .night_mode       (night_mode),
        .flash_req        (flash_req),
        .brightness_level (brightness_level),
        .fading           (fading),
        .flash_active     (flash_active)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse(input logic up, input logic dn);
        btn_up   = up;
        btn_down = dn;
        cyc(1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
    endtask

    task automatic wait_level(input string tag, input int unsigned exp,
                              input int unsigned budget, output int unsigned n);
        n = 0;
        while (32'(brightness_level) != exp && n < budget) begin
            cyc(1);
            n++;
        end
        chk(tag, 32'(brightness_level), exp);
    endtask

    task automatic hold(input string tag, input int unsigned n, input int unsigned lvl,
                        input logic fad, input logic fl);
        for (int i = 0; i < int'(n); i++) begin
            chk({tag, "_lvl"}, 32'(brightness_level), lvl);
            chk({tag, "_fading"}, 32'(fading), 32'(fad));
            chk({tag, "_flash"}, 32'(flash_active), 32'(fl));
            cyc(1);
        end
    endtask

    task automatic in_range(input string tag, input int unsigned v,
                            input int unsigned lo, input int unsigned hi);
        chk(tag, 32'(v >= lo && v <= hi), 1);
        if (v < lo || v > hi) $display("  %s interval was %0d cycles (window %0d..%0d)", tag, v, lo, hi);
    endtask

    initial begin
        reset      = 1'b1;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        night_mode = 1'b0;
        flash_req  = 1'b0;
        cyc(2);
        chk("rst_lvl", 32'(brightness_level), 5);
        chk("rst_fading", 32'(fading), 0);
        chk("rst_flash", 32'(flash_active), 0);
        reset = 1'b0;
        hold("idle", 100, 5, 1'b0, 1'b0);

        // Raise to saturation, timed fade 5 -> 6 -> 7.
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        cyc(1);
        chk("up_fading", 32'(fading), 1);
        chk("up_still5", 32'(brightness_level), 5);
        wait_level("up6", 6, 40, el);
        in_range("up6_t", el, 5, 25);
        wait_level("up7", 7, 30, el);
        in_range("up7_t", el, 19, 21);
        cyc(3);
        chk("up_done_fading", 32'(fading), 0);
        pulse(1'b1, 1'b0);
        hold("sat7", 30, 7, 1'b0, 1'b0);

        // Night clamp ramps down to 2, then back up on release.
        night_mode = 1'b1;
        wait_level("n6", 6, 40, el);
        wait_level("n5", 5, 30, el);
        in_range("n5_t", el, 19, 21);
        wait_level("n4", 4, 30, el);
        in_range("n4_t", el, 19, 21);
        wait_level("n3", 3, 30, el);
        wait_level("n2", 2, 30, el);
        cyc(3);
        hold("night2", 60, 2, 1'b0, 1'b0);
        night_mode = 1'b0;
        wait_level("n_back7", 7, 140, el);
        cyc(3);
        chk("n_back_fading", 32'(fading), 0);

        // Flash override mid-fade at level 4.
        night_mode = 1'b1;
        wait_level("f6", 6, 40, el);
        wait_level("f5", 5, 30, el);
        wait_level("f4", 4, 30, el);
        flash_req = 1'b1;
        cyc(1);
        chk("fl_on_lvl", 32'(brightness_level), 7);
        chk("fl_on_active", 32'(flash_active), 1);
        chk("fl_on_fading", 32'(fading), 0);
        wait_level("fl_off", 0, 40, el);
        in_range("fl_off_t", el, 20, 31);
        chk("fl_off_active", 32'(flash_active), 1);
        wait_level("fl_on2", 7, 40, el);
        in_range("fl_on2_t", el, 29, 31);
        flash_req = 1'b0;
        cyc(1);
        chk("fl_exit_lvl", 32'(brightness_level), 4);
        chk("fl_exit_fading", 32'(fading), 1);
        chk("fl_exit_active", 32'(flash_active), 0);
        wait_level("fl_resume3", 3, 40, el);
        wait_level("fl_resume2", 2, 30, el);
        cyc(3);
        night_mode = 1'b0;
        wait_level("fl_back7", 7, 140, el);
        cyc(3);

        // Cancelling buttons, then floor saturation.
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        wait_level("dn5", 5, 80, el);
        cyc(3);
        pulse(1'b1, 1'b1);
        hold("both", 60, 5, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) pulse(1'b0, 1'b1);
        wait_level("dn0", 0, 140, el);
        cyc(3);
        hold("zero", 40, 0, 1'b0, 1'b0);

        // Asynchronous reset while flashing dark.
        flash_req = 1'b1;
        wait_level("r_on", 7, 5, el);
        wait_level("r_off", 0, 40, el);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_lvl", 32'(brightness_level), 5);
        chk("async_rst_flash", 32'(flash_active), 0);
        chk("async_rst_fading", 32'(fading), 0);
        flash_req = 1'b0;
        cyc(3);
        reset = 1'b0;
        hold("post_rst", 100, 5, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
